// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one partial product per clock.
// Signed operands are multiplied as magnitudes and the sign is applied in the final state.
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [1:0]         dbg_state
);

    localparam int PW  = 2 * WIDTH;
    localparam int CW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    // Handshake: start is accepted only when busy=0 (IDLE); while busy=1 start is
    // ignored, not queued. done pulses for one cycle when product becomes valid, and
    // product then holds until the next accepted start has run to completion.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    cnt;
    logic             neg;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             last_iter;

    // -2^(WIDTH-1) negates to itself, which read unsigned is exactly its magnitude.
    assign a_mag     = (signed_mode && a[MSB]) ? (~a + WIDTH'(1)) : a;
    assign b_mag     = (signed_mode && b[MSB]) ? (~b + WIDTH'(1)) : b;
    assign last_iter = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CALC;
            S_CALC:  if (last_iter) state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == S_CALC) || (state == S_FIN);
        dbg_state = state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= signed_mode & (a[MSB] ^ b[MSB]);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                S_CALC: begin
                    if (mplier[0]) begin
                        acc <= acc + (PW'(mcand) << cnt);
                    end
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
                S_FIN: begin
                    product <= neg ? (~acc + PW'(1)) : acc;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
